// File: rtl/aneb_pipe_cmp_pkg.sv
// aneb_pipe_cmp_pkg: shared helpers for the pipelined not-equal comparator
package aneb_pipe_cmp_pkg;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int nstage(input int width, input int sps);
        return (width / 2 + sps - 1) / sps;
    endfunction
endpackage

// File: rtl/aneb_pipe_stage.sv
// aneb_pipe_stage: one slice-chain stage with chain, valid and residual operand registers
module aneb_pipe_stage #(
    parameter int W_IN = 8,
    parameter int NS = 4,
    localparam int RW = W_IN - 2 * NS,
    localparam int RWP = (RW > 0) ? RW : 1
) (
    input  logic            CK,
    input  logic            CD,
    input  logic            CE,
    input  logic            vi,
    input  logic            ci,
    input  logic [W_IN-1:0] a,
    input  logic [W_IN-1:0] b,
    output logic            vo,
    output logic            co,
    output logic            hit,
    output logic [RWP-1:0]  a_o,
    output logic [RWP-1:0]  b_o
);
    logic ne;
    assign ne = ci | (a[2*NS-1:0] != b[2*NS-1:0]);
    assign hit = vi & ne;
    // valid and chain bit advance together; CD drops any word in flight
    always_ff @(posedge CK)
        if (CD) {vo, co} <= '0;
        else if (CE) {vo, co} <= {vi, ne};
    if (RW > 0) begin : g_res
        // carry the not-yet-compared upper operand bits to the next stage
        always_ff @(posedge CK)
            if (CD) {a_o, b_o} <= '0;
            else if (CE) {a_o, b_o} <= {a[W_IN-1:2*NS], b[W_IN-1:2*NS]};
    end else begin : g_nores
        assign a_o = '0;
        assign b_o = '0;
    end
endmodule

// File: rtl/aneb_pipe_cmp.sv
// aneb_pipe_cmp: pipelined wide A!=B comparator with saturating mismatch count and sticky flag
module aneb_pipe_cmp
    import aneb_pipe_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICES_PER_STAGE = 4,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             CD,
    input  logic             CE,
    input  logic             VI,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    input  logic             CLR,
    output logic             VO,
    output logic             NE,
    output logic             EQ,
    output logic [CNT_W-1:0] MCNT,
    output logic             MSTKY
);
    localparam int NSLICE = WIDTH / 2;
    localparam int NSTAGE = nstage(WIDTH, SLICES_PER_STAGE);

    if (WIDTH % 2 != 0 || WIDTH < 2 || SLICES_PER_STAGE < 1) begin : g_bad
        $error("aneb_pipe_cmp: WIDTH must be even and >= 2, SLICES_PER_STAGE >= 1");
    end

    logic [NSTAGE-1:0] hits;
    logic hit;
    logic unused_bits;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_st
        localparam int REM = NSLICE - k * SLICES_PER_STAGE;
        localparam int WIN = 2 * REM;
        localparam int NS = (REM < SLICES_PER_STAGE) ? REM : SLICES_PER_STAGE;
        localparam int RWP = (WIN - 2 * NS > 0) ? WIN - 2 * NS : 1;
        logic [WIN-1:0] a_i, b_i;
        logic [RWP-1:0] a_n, b_n;
        logic c_i, v_i, c_n, v_n;
        if (k == 0) begin : g_in
            assign {a_i, b_i, c_i, v_i} = {A, B, CI, VI};
        end else begin : g_in
            assign {a_i, b_i, c_i, v_i} = {g_st[k-1].a_n, g_st[k-1].b_n, g_st[k-1].c_n, g_st[k-1].v_n};
        end
        aneb_pipe_stage #(.W_IN(WIN), .NS(NS)) u_stage (
            .CK(CK), .CD(CD), .CE(CE),
            .vi(v_i), .ci(c_i), .a(a_i), .b(b_i),
            .vo(v_n), .co(c_n), .hit(hits[k]), .a_o(a_n), .b_o(b_n)
        );
    end

    assign hit = hits[NSTAGE-1];
    assign unused_bits = ^{hits, g_st[NSTAGE-1].a_n, g_st[NSTAGE-1].b_n};
    assign VO = g_st[NSTAGE-1].v_n;
    assign NE = VO & g_st[NSTAGE-1].c_n;
    assign EQ = VO & ~g_st[NSTAGE-1].c_n;

    // count mismatches as they load into the output stage; CLR beats a same-edge increment
    always_ff @(posedge CK)
        if (CD) {MCNT, MSTKY} <= '0;
        else if (CE) begin
            MCNT <= CLR ? '0 : (hit && MCNT != '1) ? MCNT + CNT_W'(1) : MCNT;
            MSTKY <= ~CLR & (MSTKY | hit);
        end
endmodule

// File: tb/tb_aneb_pipe_cmp.sv
// tb_aneb_pipe_cmp: directed plus random checks of aneb_pipe_cmp against a word-level model
module tb_aneb_pipe_cmp;
    localparam int W = 16;
    localparam int L = (W / 2 + 3) / 4;
    localparam int CMAX = 255;

    logic CK = 0, CD = 1, CE = 1, VI = 0, CI = 0, CLR = 0;
    logic [W-1:0] A = '0, B = '0;
    logic VO, NE, EQ, MSTKY;
    logic [7:0] MCNT;

    bit mv[L], mn[L];
    int cnt = 0;
    bit stk = 0;
    int n_cmp = 0, n_err = 0;

    aneb_pipe_cmp dut (
        .CK(CK), .CD(CD), .CE(CE), .VI(VI), .A(A), .B(B), .CI(CI), .CLR(CLR),
        .VO(VO), .NE(NE), .EQ(EQ), .MCNT(MCNT), .MSTKY(MSTKY)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        if (CD) begin
            for (int i = 0; i < L; i++) begin mv[i] = 0; mn[i] = 0; end
            cnt = 0;
            stk = 0;
        end else if (CE) begin
            for (int i = L - 1; i > 0; i--) begin mv[i] = mv[i-1]; mn[i] = mn[i-1]; end
            mv[0] = VI;
            mn[0] = CI || (A != B);
            if (CLR) begin
                cnt = 0;
                stk = 0;
            end else if (mv[L-1] && mn[L-1]) begin
                if (cnt < CMAX) cnt++;
                stk = 1;
            end
        end
        #1;
        chk("vo", 32'(VO), 32'(mv[L-1]));
        chk("ne", 32'(NE), 32'(mv[L-1] & mn[L-1]));
        chk("eq", 32'(EQ), 32'(mv[L-1] & ~mn[L-1]));
        chk("mcnt", 32'(MCNT), 32'(cnt));
        chk("mstky", 32'(MSTKY), 32'(stk));
    endtask

    task automatic drive(input logic ce, input logic vi, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic clr, input logic cd);
        CE = ce; VI = vi; A = a; B = b; CI = ci; CLR = clr; CD = cd;
        step();
    endtask

    initial begin
        drive(1, 1, 16'h1234, 16'h0000, 0, 0, 1);
        drive(1, 1, 16'h1234, 16'h0000, 0, 0, 1);
        chk("reset_mcnt", 32'(MCNT), 0);
        drive(1, 1, 16'hA5A5, 16'hA5A5, 0, 0, 0);
        drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        chk("eq_word", 32'(EQ), 1);
        drive(1, 1, 16'h8000, 16'h0000, 0, 0, 0);
        drive(1, 1, 16'h0001, 16'h0000, 0, 0, 0);
        chk("msb_mcnt", 32'(MCNT), 1);
        drive(1, 1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
        chk("lsb_mcnt", 32'(MCNT), 2);
        drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        chk("ci_ne", 32'(NE), 1);
        drive(1, 1, 16'h0F0F, 16'h0F0F, 0, 0, 1);
        drive(1, 1, 16'h0F0F, 16'h0F0F, 0, 0, 0);
        drive(1, 1, 16'h0F0F, 16'h0F0E, 0, 0, 0);
        drive(0, 1, 16'h3C3C, 16'h3C3C, 0, 0, 0);
        drive(1, 1, 16'h3C3C, 16'h3C3C, 0, 0, 0);
        drive(1, 1, 16'h3C3C, 16'hBC3C, 0, 0, 0);
        drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        chk("stream_mcnt", 32'(MCNT), 2);
        for (int i = 0; i < 300; i++) drive(1, 1, 16'h0001, 16'h0000, 0, 0, 0);
        chk("sat_mcnt", 32'(MCNT), 255);
        drive(1, 0, 16'h0, 16'h0, 0, 1, 0);
        chk("clr_mcnt", 32'(MCNT), 0);
        chk("clr_stky", 32'(MSTKY), 0);
        drive(1, 1, 16'h0001, 16'h0000, 0, 0, 0);
        drive(1, 1, 16'h0002, 16'h0000, 0, 0, 0);
        drive(0, 0, 16'h0, 16'h0, 0, 1, 0);
        chk("clr_ce0_mcnt", 32'(MCNT), 1);
        drive(1, 1, 16'h0004, 16'h0000, 0, 0, 0);
        drive(1, 1, 16'h0008, 16'h0000, 0, 0, 0);
        drive(1, 0, 16'h0, 16'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(1, 0, 16'h0, 16'h0, 0, 0, 0);
        chk("flush_vo", 32'(VO), 0);
        for (int i = 0; i < 600; i++) begin
            A = 16'($urandom);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, A,
                  $urandom_range(0, 1) ? A : A ^ (16'h1 << $urandom_range(0, 15)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
